// File: rtl/fixed_pkg.sv
// Fixed-point (Q19.12) types and vector helpers shared by the camera-setup pipeline.
package fixed_pkg;

  localparam int unsigned FIXED_WIDTH = 32;
  localparam int unsigned FIXED_FRAC  = 12;

  typedef logic signed [FIXED_WIDTH-1:0]   Fixed;
  typedef logic signed [2*FIXED_WIDTH-1:0] FixedWide;

  typedef struct packed {
    Fixed x;
    Fixed y;
    Fixed z;
  } Fixed3;

  typedef struct packed {
    Fixed3 U;
    Fixed3 V;
    Fixed3 W;
    Fixed3 RH;
    Fixed3 RV;
    Fixed3 BLC;
  } Camera;

  // Integer to Fixed.
  function automatic Fixed _Fixed(int v);
    Fixed r;
    r = v;
    return r <<< FIXED_FRAC;
  endfunction

  // Integer-unit triple to Fixed3.
  function automatic Fixed3 _Fixed3u(int x, int y, int z);
    Fixed3 r;
    r.x = _Fixed(x);
    r.y = _Fixed(y);
    r.z = _Fixed(z);
    return r;
  endfunction

  function automatic Fixed fixed_mul(Fixed a, Fixed b);
    FixedWide pa, pb, p;
    pa = a;
    pb = b;
    p  = (pa * pb) >>> FIXED_FRAC;
    return p[FIXED_WIDTH-1:0];
  endfunction

  function automatic Fixed3 fixed3_add(Fixed3 a, Fixed3 b);
    Fixed3 r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    r.z = a.z + b.z;
    return r;
  endfunction

  function automatic Fixed3 fixed3_sub(Fixed3 a, Fixed3 b);
    Fixed3 r;
    r.x = a.x - b.x;
    r.y = a.y - b.y;
    r.z = a.z - b.z;
    return r;
  endfunction

  function automatic Fixed3 fixed3_scale(Fixed3 a, Fixed s);
    Fixed3 r;
    r.x = fixed_mul(a.x, s);
    r.y = fixed_mul(a.y, s);
    r.z = fixed_mul(a.z, s);
    return r;
  endfunction

  function automatic Fixed3 fixed3_half(Fixed3 a);
    Fixed3 r;
    r.x = a.x >>> 1;
    r.y = a.y >>> 1;
    r.z = a.z >>> 1;
    return r;
  endfunction

  // Full-precision dot product; the result carries 2*FIXED_FRAC fractional bits.
  function automatic FixedWide fixed3_dot(Fixed3 a, Fixed3 b);
    FixedWide ax, ay, az, bx, by, bz;
    ax = a.x; ay = a.y; az = a.z;
    bx = b.x; by = b.y; bz = b.z;
    return ax * bx + ay * by + az * bz;
  endfunction

  function automatic Fixed3 fixed3_cross(Fixed3 a, Fixed3 b);
    Fixed3 r;
    r.x = fixed_mul(a.y, b.z) - fixed_mul(a.z, b.y);
    r.y = fixed_mul(a.z, b.x) - fixed_mul(a.x, b.z);
    r.z = fixed_mul(a.x, b.y) - fixed_mul(a.y, b.x);
    return r;
  endfunction

endpackage

// File: rtl/fixed3_normalize.sv
// Combinational vector normalisation: wide dot, integer square root, per-component divide.
module fixed3_normalize
  import fixed_pkg::*;
(
  input  Fixed3 vec_i,
  output Fixed3 unit_o
);

  logic [2*FIXED_WIDTH-1:0] dot;
  Fixed                     len;

  // Digit-by-digit root of a Q.24 value lands directly in Q.12.
  always_comb begin : sqrt_dot
    logic [2*FIXED_WIDTH-1:0] rem, root, bit_w;
    dot   = fixed3_dot(vec_i, vec_i);
    rem   = dot;
    root  = '0;
    bit_w = 64'd1 << (2 * FIXED_WIDTH - 2);
    for (int i = 0; i < FIXED_WIDTH; i++) begin
      if (rem >= root + bit_w) begin
        rem  = rem - (root + bit_w);
        root = (root >> 1) + bit_w;
      end else begin
        root = root >> 1;
      end
      bit_w = bit_w >> 2;
    end
    len = root[FIXED_WIDTH-1:0];
  end

  function automatic Fixed div_len(Fixed c, Fixed l);
    FixedWide num, den, q;
    num = c;
    num = num <<< FIXED_FRAC;
    den = {{FIXED_WIDTH{1'b0}}, l};
    q   = num / den;
    return q[FIXED_WIDTH-1:0];
  endfunction

  always_comb begin
    unit_o = '0;
    if (len != '0) begin
      unit_o.x = div_len(vec_i.x, len);
      unit_o.y = div_len(vec_i.y, len);
      unit_o.z = div_len(vec_i.z, len);
    end
  end

endmodule

// File: rtl/render_state_camera.sv
// Camera-setup stage: eight-stage pipeline deriving basis U/V/W, viewport spans and corner.
module render_state_camera
  import fixed_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  Fixed3 pos,
  input  Fixed3 look,
  input  Fixed  focus_dist,
  input  Fixed  vp_w,
  input  Fixed  vp_h,
  output Camera camera
);

  localparam Fixed3 VUP = _Fixed3u(0, 1, 0);

  typedef struct packed {
    Fixed3 pos;
    Fixed  focus;
    Fixed  vp_w;
    Fixed  vp_h;
  } params_t;

  typedef struct packed { Fixed3 d;    params_t p; } s1_t;
  typedef struct packed { Fixed3 w;    params_t p; } s2_t;
  typedef struct packed { Fixed3 c, w; params_t p; } s3_t;
  typedef struct packed { Fixed3 u, w; params_t p; } s4_t;
  typedef struct packed {
    Fixed3 u, v, w, fw_vec, pos;
    Fixed  fw, fh;
  } s5_t;
  typedef struct packed { Fixed3 u, v, w, rh, rv, fw_vec, pos; } s6_t;

  s1_t   s1_d, s1_q;
  s2_t   s2_d, s2_q;
  s3_t   s3_d, s3_q;
  s4_t   s4_d, s4_q;
  s5_t   s5_d, s5_q;
  s6_t   s6_d, s6_q;
  Camera s7_d, s7_q;
  Camera camera_d, camera_q;

  Fixed3 w_unit, u_unit;

  fixed3_normalize u_norm_w (
    .vec_i  (s1_q.d),
    .unit_o (w_unit)
  );

  fixed3_normalize u_norm_u (
    .vec_i  (s3_q.c),
    .unit_o (u_unit)
  );

  always_comb begin
    s1_d.d       = fixed3_sub(pos, look);
    s1_d.p.pos   = pos;
    s1_d.p.focus = focus_dist;
    s1_d.p.vp_w  = vp_w;
    s1_d.p.vp_h  = vp_h;

    s2_d.w = w_unit;
    s2_d.p = s1_q.p;

    s3_d.c = fixed3_cross(VUP, s2_q.w);
    s3_d.w = s2_q.w;
    s3_d.p = s2_q.p;

    s4_d.u = u_unit;
    s4_d.w = s3_q.w;
    s4_d.p = s3_q.p;

    s5_d.u      = s4_q.u;
    s5_d.w      = s4_q.w;
    s5_d.v      = fixed3_cross(s4_q.w, s4_q.u);
    s5_d.fw     = fixed_mul(s4_q.p.focus, s4_q.p.vp_w);
    s5_d.fh     = fixed_mul(s4_q.p.focus, s4_q.p.vp_h);
    s5_d.fw_vec = fixed3_scale(s4_q.w, s4_q.p.focus);
    s5_d.pos    = s4_q.p.pos;

    s6_d.u      = s5_q.u;
    s6_d.v      = s5_q.v;
    s6_d.w      = s5_q.w;
    s6_d.rh     = fixed3_scale(s5_q.u, s5_q.fw);
    s6_d.rv     = fixed3_scale(s5_q.v, s5_q.fh);
    s6_d.fw_vec = s5_q.fw_vec;
    s6_d.pos    = s5_q.pos;

    s7_d.U   = s6_q.u;
    s7_d.V   = s6_q.v;
    s7_d.W   = s6_q.w;
    s7_d.RH  = s6_q.rh;
    s7_d.RV  = s6_q.rv;
    s7_d.BLC = fixed3_sub(fixed3_sub(fixed3_sub(s6_q.pos, fixed3_half(s6_q.rh)),
                                     fixed3_half(s6_q.rv)), s6_q.fw_vec);

    camera_d = s7_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      s4_q     <= '0;
      s5_q     <= '0;
      s6_q     <= '0;
      s7_q     <= '0;
      camera_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      s4_q     <= s4_d;
      s5_q     <= s5_d;
      s6_q     <= s6_d;
      s7_q     <= s7_d;
      camera_q <= camera_d;
    end
  end

  assign camera = camera_q;

endmodule

// File: tb/tb_render_state_camera.sv
// Directed self-checking bench for render_state_camera with an integer reference model.
module tb_render_state_camera;
  import fixed_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  Fixed3 pos, look;
  Fixed  focus_dist, vp_w, vp_h;
  Camera camera;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  render_state_camera dut (
    .clk        (clk),
    .rst        (rst),
    .pos        (pos),
    .look       (look),
    .focus_dist (focus_dist),
    .vp_w       (vp_w),
    .vp_h       (vp_h),
    .camera     (camera)
  );

  // ---------------- reference model ----------------
  function automatic int m_mul(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 12);
  endfunction

  function automatic longint m_sqrt(longint unsigned v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'hFFFF_FFFF;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return longint'(lo);
  endfunction

  function automatic void m_norm(input int v[3], output int o[3]);
    longint unsigned dot;
    longint len, n;
    dot = 0;
    for (int i = 0; i < 3; i++) dot += longint'(v[i]) * longint'(v[i]);
    len = m_sqrt(dot);
    for (int i = 0; i < 3; i++) begin
      if (len == 0) begin
        o[i] = 0;
      end else begin
        n    = longint'(v[i]) * 4096;
        o[i] = int'(n / len);
      end
    end
  endfunction

  function automatic void m_camera(input int p[3], input int l[3], input int f, input int w,
                                   input int h, output int e[18]);
    int d[3], wv[3], c[3], u[3], v[3];
    int fw, fh;
    for (int i = 0; i < 3; i++) d[i] = p[i] - l[i];
    m_norm(d, wv);
    c[0] = wv[2];
    c[1] = 0;
    c[2] = -wv[0];
    m_norm(c, u);
    v[0] = m_mul(wv[1], u[2]) - m_mul(wv[2], u[1]);
    v[1] = m_mul(wv[2], u[0]) - m_mul(wv[0], u[2]);
    v[2] = m_mul(wv[0], u[1]) - m_mul(wv[1], u[0]);
    fw = m_mul(f, w);
    fh = m_mul(f, h);
    for (int i = 0; i < 3; i++) begin
      e[i]      = u[i];
      e[3 + i]  = v[i];
      e[6 + i]  = wv[i];
      e[9 + i]  = m_mul(u[i], fw);
      e[12 + i] = m_mul(v[i], fh);
      e[15 + i] = p[i] - (e[9 + i] >>> 1) - (e[12 + i] >>> 1) - m_mul(wv[i], f);
    end
  endfunction

  // ---------------- stimulus / readout ----------------
  task automatic drive(input int p[3], input int l[3], input int f, input int w, input int h);
    pos.x      = p[0];
    pos.y      = p[1];
    pos.z      = p[2];
    look.x     = l[0];
    look.y     = l[1];
    look.z     = l[2];
    focus_dist = f;
    vp_w       = w;
    vp_h       = h;
  endtask

  function automatic void grab(output logic [31:0] g[18]);
    g[0]  = camera.U.x;   g[1]  = camera.U.y;   g[2]  = camera.U.z;
    g[3]  = camera.V.x;   g[4]  = camera.V.y;   g[5]  = camera.V.z;
    g[6]  = camera.W.x;   g[7]  = camera.W.y;   g[8]  = camera.W.z;
    g[9]  = camera.RH.x;  g[10] = camera.RH.y;  g[11] = camera.RH.z;
    g[12] = camera.RV.x;  g[13] = camera.RV.y;  g[14] = camera.RV.z;
    g[15] = camera.BLC.x; g[16] = camera.BLC.y; g[17] = camera.BLC.z;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] g[18];
    int z[3];
    z = '{0, 0, 0};
    rst = 1'b1;
    drive(z, z, 0, 0, 0);
    repeat (3) @(negedge clk);
    grab(g);
    for (int i = 0; i < 18; i++) begin
      total++;
      if (g[i] !== 32'd0) begin
        bad++;
        $display("FAIL reset_state field=%0d got=%h want=0", i, g[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] g[18];
    int p[3], l[3], e[18], ref_v[12], tol[12], diff;
    p = '{15 * 4096, 15 * 4096, -25 * 4096};
    l = '{0, -5 * 4096, 0};
    ref_v = '{-3512, 0, -2107, -1192, 3378, 1987, 1738, 2317, -2896, -216300, 0, -129800};
    tol   = '{8, 8, 8, 8, 8, 8, 8, 8, 8, 1000, 1000, 1000};
    m_camera(p, l, 40960, 25224, 18919, e);
    @(negedge clk);
    drive(p, l, 40960, 25224, 18919);
    repeat (8) @(negedge clk);
    grab(g);
    for (int i = 0; i < 18; i++) begin
      total++;
      if (g[i] !== e[i]) begin
        bad++;
        $display("FAIL basic field=%0d got=%0d want=%0d", i, $signed(g[i]), e[i]);
      end
    end
    // Independent check of U, V, W, RH against precomputed real-valued results.
    for (int i = 0; i < 12; i++) begin
      diff = $signed(g[i]) - ref_v[i];
      if (diff < 0) diff = -diff;
      total++;
      if (diff > tol[i]) begin
        bad++;
        $display("FAIL basic_tol field=%0d got=%0d want=%0d+-%0d", i, $signed(g[i]), ref_v[i],
                 tol[i]);
      end
    end
  endtask

  task automatic test_axis();
    logic [31:0] g[18];
    int p[3], l[3], e[18];
    p = '{0, 0, 10 * 4096};
    l = '{0, 0, 0};
    e = '{4096, 0, 0, 0, 4096, 0, 0, 0, 4096, 4096, 0, 0, 0, 4096, 0, -2048, -2048, 36864};
    @(negedge clk);
    drive(p, l, 4096, 4096, 4096);
    repeat (8) @(negedge clk);
    grab(g);
    for (int i = 0; i < 18; i++) begin
      total++;
      if (g[i] !== e[i]) begin
        bad++;
        $display("FAIL axis field=%0d got=%0d want=%0d", i, $signed(g[i]), e[i]);
      end
    end
  endtask

  task automatic test_degenerate();
    logic [31:0] g[18];
    int p[3], e[18];
    p = '{3 * 4096 + 123, -7 * 4096, 2 * 4096 + 5};
    e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3 * 4096 + 123, -7 * 4096, 2 * 4096 + 5};
    @(negedge clk);
    drive(p, p, 40960, 25224, 18919);
    repeat (8) @(negedge clk);
    grab(g);
    total++;
    if ($isunknown(camera)) begin
      bad++;
      $display("FAIL degenerate_x got=%h want=no X bits", camera);
    end
    for (int i = 0; i < 18; i++) begin
      total++;
      if (g[i] !== e[i]) begin
        bad++;
        $display("FAIL degenerate field=%0d got=%0d want=%0d", i, $signed(g[i]), e[i]);
      end
    end
  endtask

  task automatic test_vertical();
    logic [31:0] g[18];
    int p[3], l[3], e[18];
    p = '{0, 10 * 4096, 0};
    l = '{0, 0, 0};
    // W points up; U, V, spans vanish; BLC = pos - 10*W = 0.
    e = '{0, 0, 0, 0, 0, 0, 0, 4096, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    drive(p, l, 40960, 4096, 4096);
    repeat (8) @(negedge clk);
    grab(g);
    for (int i = 0; i < 18; i++) begin
      total++;
      if (g[i] !== e[i]) begin
        bad++;
        $display("FAIL vertical field=%0d got=%0d want=%0d", i, $signed(g[i]), e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] g[18];
    int p[3], l[3], e[18];
    p = '{15 * 4096, 15 * 4096, -25 * 4096};
    l = '{0, -5 * 4096, 0};
    m_camera(p, l, 40960, 25224, 18919, e);
    @(negedge clk);
    drive(p, l, 40960, 25224, 18919);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 grab(g);
    for (int i = 0; i < 18; i++) begin
      total++;
      if (g[i] !== 32'd0) begin
        bad++;
        $display("FAIL reset_async field=%0d got=%h want=0", i, g[i]);
      end
    end
    @(posedge clk);
    #1 grab(g);
    for (int i = 0; i < 18; i++) begin
      total++;
      if (g[i] !== 32'd0) begin
        bad++;
        $display("FAIL reset_held field=%0d got=%h want=0", i, g[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    grab(g);
    for (int i = 0; i < 18; i++) begin
      total++;
      if (g[i] !== 32'd0) begin
        bad++;
        $display("FAIL reset_flush field=%0d got=%h want=0", i, g[i]);
      end
    end
    @(negedge clk);
    grab(g);
    for (int i = 0; i < 18; i++) begin
      total++;
      if (g[i] !== e[i]) begin
        bad++;
        $display("FAIL reset_first field=%0d got=%0d want=%0d", i, $signed(g[i]), e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g[18];
    int tp[10][3], tl[10][3], tf[10], tw[10], th[10], ex[10][18];
    int p[3], l[3], e[18];
    for (int j = 0; j < 10; j++) begin
      tp[j][0] = ((j * 7) % 23 - 11) * 4096 + j * 37;
      tp[j][1] = ((j * 5) % 13 - 6) * 4096 - j * 91;
      tp[j][2] = ((j * 3) % 17 - 8) * 4096 + 700;
      tl[j][0] = (j - 4) * 4096;
      tl[j][1] = 2 * 4096 + j * 11;
      tl[j][2] = -j * 4096;
      tf[j] = 4096 + j * 1000;
      tw[j] = 8192 + j * 311;
      th[j] = 6000 + j * 97;
      for (int k = 0; k < 3; k++) begin
        p[k] = tp[j][k];
        l[k] = tl[j][k];
      end
      m_camera(p, l, tf[j], tw[j], th[j], e);
      for (int k = 0; k < 18; k++) ex[j][k] = e[k];
    end
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      if (n >= 8) begin
        grab(g);
        for (int i = 0; i < 18; i++) begin
          total++;
          if (g[i] !== ex[n - 8][i]) begin
            bad++;
            $display("FAIL b2b vec=%0d field=%0d got=%0d want=%0d", n - 8, i, $signed(g[i]),
                     ex[n - 8][i]);
          end
        end
      end
      if (n < 10) begin
        for (int k = 0; k < 3; k++) begin
          p[k] = tp[n][k];
          l[k] = tl[n][k];
        end
        drive(p, l, tf[n], tw[n], th[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_axis();
    test_degenerate();
    test_vertical();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
